// File: rtl/gate_fault_pkg.sv
// Shared types and helpers for the multi-channel faulty gate bank.
package gate_fault_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned MODE_W = 3;
  localparam int unsigned POP_IN_W = 16;
  localparam int unsigned POP_W = 5;

  typedef enum logic [MODE_W-1:0] {
    GM_AND  = 3'd0,
    GM_OR   = 3'd1,
    GM_XOR  = 3'd2,
    GM_NAND = 3'd3,
    GM_NOR  = 3'd4,
    GM_XNOR = 3'd5
  } gate_mode_e;

  function automatic logic [POP_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(POP_IN_W); i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fault_lfsr16.sv
// 16-bit Galois LFSR that steps only when asked; reloads the seed on reset.
module fault_lfsr16
  import gate_fault_pkg::*;
(
  input  logic              clk,
  input  logic              logic_reset_n,
  input  logic              advance,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (advance) begin
      state_d = {1'b0, state_q[LFSR_W-1:1]} ^ (state_q[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/gate_fault_bank.sv
// Bank of independent logic-gate channels sharing one LFSR, served one per
// cycle by a round-robin arbiter over latched evaluation requests.
module gate_fault_bank
  import gate_fault_pkg::*;
#(
  parameter int unsigned      CHANNELS     = 4,
  parameter int unsigned      INPUT_COUNT  = 4,
  parameter int unsigned      OUTPUT_COUNT = 2,
  parameter logic [LFSR_W-1:0] RAND_SEED   = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             logic_reset_n,
  input  logic [CHANNELS*INPUT_COUNT-1:0]  in,
  input  logic [CHANNELS-1:0]              fault_in,
  input  logic [CHANNELS*MODE_W-1:0]       mode,
  input  logic [CHANNELS-1:0]              trigger,
  output logic [CHANNELS*OUTPUT_COUNT-1:0] out,
  output logic [CHANNELS-1:0]              out_valid,
  output logic                             busy
);

  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned SUM_W = CH_W + 1;
  localparam logic [LFSR_W-1:0] SEED_EFF = (RAND_SEED == '0) ? 16'h0001 : RAND_SEED;

  logic [CHANNELS-1:0]              p_q, p_d;
  logic [CH_W-1:0]                  ptr_q, ptr_d;
  logic [CHANNELS*OUTPUT_COUNT-1:0] out_q, out_d;
  logic [CHANNELS-1:0]              out_valid_q, out_valid_d;
  logic                             busy_q, busy_d;

  logic                gnt_vld_c;
  logic [CH_W-1:0]     gnt_idx_c;
  logic [CHANNELS-1:0] gnt_oh_c;

  logic [INPUT_COUNT-1:0] sel_in_c;
  logic [MODE_W-1:0]      sel_mode_c;
  logic                   sel_fault_c;
  logic [POP_W-1:0]       k_c;
  logic                   mode_res_c;
  logic                   fault_res_c;
  logic                   res_c;
  logic                   lfsr_adv_c;
  logic [LFSR_W-1:0]      lfsr_state;
  logic                   unused_lfsr_hi;

  fault_lfsr16 u_lfsr (
    .clk          (clk),
    .logic_reset_n(logic_reset_n),
    .advance      (lfsr_adv_c),
    .seed         (SEED_EFF),
    .state        (lfsr_state)
  );

  assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:8];

  // Priority encoder rotated to start at ptr_q, wrapping past the top channel.
  always_comb begin
    logic [SUM_W-1:0] cand;
    cand      = '0;
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    gnt_oh_c  = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cand = SUM_W'(ptr_q) + SUM_W'(i);
      if (cand >= SUM_W'(CHANNELS)) begin
        cand = cand - SUM_W'(CHANNELS);
      end
      if (!gnt_vld_c && p_q[cand[CH_W-1:0]]) begin
        gnt_vld_c               = 1'b1;
        gnt_idx_c               = cand[CH_W-1:0];
        gnt_oh_c[cand[CH_W-1:0]] = 1'b1;
      end
    end
  end

  // Evaluate the granted channel with its live inputs.
  always_comb begin
    sel_in_c    = '0;
    sel_mode_c  = '0;
    sel_fault_c = 1'b0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (gnt_idx_c == CH_W'(c)) begin
        sel_in_c    = in[c*INPUT_COUNT +: INPUT_COUNT];
        sel_mode_c  = mode[c*MODE_W +: MODE_W];
        sel_fault_c = fault_in[c];
      end
    end

    k_c = popcount(POP_IN_W'(sel_in_c));

    case (sel_mode_c)
      GM_AND:  mode_res_c = (k_c == POP_W'(INPUT_COUNT));
      GM_OR:   mode_res_c = (k_c != '0);
      GM_XOR:  mode_res_c = k_c[0];
      GM_NAND: mode_res_c = (k_c != POP_W'(INPUT_COUNT));
      GM_NOR:  mode_res_c = (k_c == '0);
      GM_XNOR: mode_res_c = ~k_c[0];
      default: mode_res_c = 1'b0;
    endcase

    // Fault: output 1 with probability k/INPUT_COUNT using the low LFSR byte.
    fault_res_c = ((16'(lfsr_state[7:0]) * 16'(INPUT_COUNT)) < (16'(k_c) << 8));
    res_c       = sel_fault_c ? fault_res_c : mode_res_c;
    lfsr_adv_c  = gnt_vld_c & sel_fault_c;
  end

  always_comb begin
    logic [SUM_W-1:0] nxt;
    nxt         = '0;
    p_d         = (p_q & ~gnt_oh_c) | trigger;
    ptr_d       = ptr_q;
    out_d       = out_q;
    out_valid_d = gnt_oh_c;
    busy_d      = |p_d;
    if (gnt_vld_c) begin
      nxt = SUM_W'(gnt_idx_c) + SUM_W'(1);
      if (nxt >= SUM_W'(CHANNELS)) begin
        nxt = '0;
      end
      ptr_d = nxt[CH_W-1:0];
    end
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (gnt_oh_c[c]) begin
        out_d[c*OUTPUT_COUNT +: OUTPUT_COUNT] = {OUTPUT_COUNT{res_c}};
      end
    end
  end

  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      p_q         <= '0;
      ptr_q       <= '0;
      out_q       <= '0;
      out_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      p_q         <= p_d;
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
